// File: rtl/tdm_pkg.sv
// tdm_pkg
//   Definitions shared by the TDM mux/demux pair.
//   - tdm_state_t : framing state of the receive side (HUNT searching, LOCK aligned)
//   - TDM_NCH     : default number of channels (slots) per frame
//   - TDM_WIDTH   : default bits per sample
package tdm_pkg;

   typedef enum logic {
      HUNT = 1'b0,
      LOCK = 1'b1
   } tdm_state_t;

   localparam int TDM_NCH   = 4;
   localparam int TDM_WIDTH = 8;

endpackage

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr
//   Slot position and consecutive-miss counter for the TDM demux.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     clear      : slot <= 0, miss <= 0 (loss of lock)
//     load0      : a slot-0 sample was written; slot <= 1 and
//                  miss <= miss+1 when miss_inc, else miss <= 0
//     inc        : a nonzero slot was written; slot <= slot+1 (wraps mod NCH)
//     miss_inc   : qualifies load0 (slot 0 arrived without in_sof)
//     slot       : slot index expected for the next sample
//     miss       : consecutive frames whose slot 0 lacked in_sof
//   Priority: rst/clear > load0 > inc.
module tdm_slot_ctr #(
   parameter int NCH    = 4,
   parameter int MISS_W = 2,
   localparam int SW    = $clog2(NCH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              load0,
   input  logic              inc,
   input  logic              miss_inc,
   output logic [SW-1:0]     slot,
   output logic [MISS_W-1:0] miss
);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         slot <= '0;
         miss <= '0;
      end else if (load0) begin
         slot <= SW'(1);
         miss <= miss_inc ? (miss + MISS_W'(1)) : '0;
      end else if (inc) begin
         // NCH is a power of two, so the natural overflow is the wrap to slot 0.
         slot <= slot + SW'(1);
      end
   end

endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4
//   Receive side of the TDM path: locks onto the frame marked by in_sof,
//   steers each accepted sample into its channel register and flags
//   complete, aligned frames. Recovers from misplaced in_sof (err_frame)
//   and drops lock after SYNC_MISS_MAX consecutive frames whose slot 0
//   lacked in_sof.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     in_valid     : one sample accepted per valid cycle
//     in_data      : sample
//     in_sof       : start of frame, qualified by in_valid
//     ch_data      : channel registers, ch k = [k*WIDTH +: WIDTH]
//     ch_strobe    : one-hot pulse, channel k written this cycle
//     frame_valid  : pulse, ch_data holds a complete aligned frame
//     locked       : high while in LOCK (also the FSM state observation point)
//     err_frame    : pulse, in_sof seen at a nonzero slot
//   Handshake: no backpressure. A sample is taken on every rising edge with
//   in_valid=1; its effect is visible on the outputs right after that edge.
//   All pulses are single-cycle and are 0 after an edge with in_valid=0.
module tdm_demux4
   import tdm_pkg::*;
#(
   parameter int WIDTH         = TDM_WIDTH,
   parameter int NCH           = TDM_NCH,
   parameter int SYNC_MISS_MAX = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     in_data,
   input  logic                 in_sof,
   output logic [NCH*WIDTH-1:0] ch_data,
   output logic [NCH-1:0]       ch_strobe,
   output logic                 frame_valid,
   output logic                 locked,
   output logic                 err_frame
);

   localparam int SW = $clog2(NCH);
   localparam int MW = $clog2(SYNC_MISS_MAX + 1);

   tdm_state_t    state;
   tdm_state_t    state_next;
   logic [SW-1:0] slot;
   logic [MW-1:0] miss;

   logic          wr_en;
   logic [SW-1:0] wr_idx;
   logic          err_next;
   logic          ctr_clear;
   logic          ctr_load0;
   logic          ctr_inc;
   logic          ctr_miss_inc;

   tdm_slot_ctr #(
      .NCH    (NCH),
      .MISS_W (MW)
   ) u_slot_ctr (
      .clk      (clk),
      .rst      (rst),
      .clear    (ctr_clear),
      .load0    (ctr_load0),
      .inc      (ctr_inc),
      .miss_inc (ctr_miss_inc),
      .slot     (slot),
      .miss     (miss)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= HUNT;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next   = state;
      wr_en        = 1'b0;
      wr_idx       = '0;
      err_next     = 1'b0;
      ctr_clear    = 1'b0;
      ctr_load0    = 1'b0;
      ctr_inc      = 1'b0;
      ctr_miss_inc = 1'b0;
      if (in_valid) begin
         case (state)
            HUNT: begin
               // Samples without in_sof are discarded until alignment is found.
               if (in_sof) begin
                  wr_en      = 1'b1;
                  ctr_load0  = 1'b1;
                  state_next = LOCK;
               end
            end
            LOCK: begin
               if (slot == '0) begin
                  if (in_sof) begin
                     wr_en     = 1'b1;
                     ctr_load0 = 1'b1;
                  end else if (miss == MW'(SYNC_MISS_MAX - 1)) begin
                     // This miss reaches the limit: drop the sample and re-hunt.
                     ctr_clear  = 1'b1;
                     state_next = HUNT;
                  end else begin
                     wr_en        = 1'b1;
                     ctr_load0    = 1'b1;
                     ctr_miss_inc = 1'b1;
                  end
               end else if (in_sof) begin
                  // Misplaced sof: abandon the partial frame and restart at slot 0.
                  err_next  = 1'b1;
                  wr_en     = 1'b1;
                  ctr_load0 = 1'b1;
               end else begin
                  wr_en   = 1'b1;
                  wr_idx  = slot;
                  ctr_inc = 1'b1;
               end
            end
            default: begin
               state_next = HUNT;
            end
         endcase
      end
   end

   // Slots only advance on in-order writes and every restart goes through a
   // fresh slot-0 write, so a write to the last slot closes an aligned frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         ch_data     <= '0;
         ch_strobe   <= '0;
         frame_valid <= 1'b0;
         err_frame   <= 1'b0;
      end else begin
         ch_strobe <= '0;
         if (wr_en) begin
            ch_data[wr_idx*WIDTH +: WIDTH] <= in_data;
            ch_strobe[wr_idx]              <= 1'b1;
         end
         frame_valid <= wr_en && (wr_idx == SW'(NCH - 1));
         err_frame   <= err_next;
      end
   end

   assign locked = (state == LOCK);

endmodule

// File: tb/tb_tdm_demux4.sv
module tb_tdm_demux4;

   localparam int WIDTH = 8;
   localparam int NCH   = 4;
   localparam int NVEC  = 36;

   logic                 clk;
   logic                 rst;
   logic                 in_valid;
   logic [WIDTH-1:0]     in_data;
   logic                 in_sof;
   logic [NCH*WIDTH-1:0] ch_data;
   logic [NCH-1:0]       ch_strobe;
   logic                 frame_valid;
   logic                 locked;
   logic                 err_frame;

   int checks = 0;
   int errors = 0;

   logic [NCH*WIDTH-1:0] exp_q[$];
   logic                 sb_on = 1'b0;

   typedef struct {
      logic             rst;
      logic             v;
      logic             sof;
      logic [7:0]       d;
      logic [3:0]       strb;
      logic             fv;
      logic             err;
      logic             lk;
      logic [31:0]      ch;
   } vec_t;

   vec_t tbl[NVEC];

   tdm_demux4 #(
      .WIDTH         (WIDTH),
      .NCH           (NCH),
      .SYNC_MISS_MAX (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_sof      (in_sof),
      .ch_data     (ch_data),
      .ch_strobe   (ch_strobe),
      .frame_valid (frame_valid),
      .locked      (locked),
      .err_frame   (err_frame)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic v, input logic s,
                               input logic [7:0] d, input logic [3:0] strb,
                               input logic fv, input logic err, input logic lk,
                               input logic [31:0] ch);
      vec_t x;
      x.rst = r; x.v = v; x.sof = s; x.d = d; x.strb = strb;
      x.fv = fv; x.err = err; x.lk = lk; x.ch = ch;
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // driver: present one cycle of stimulus, then check outputs 1 ns after the edge
   task automatic apply(input int idx, input vec_t x);
      string tag;
      @(negedge clk);
      rst      = x.rst;
      in_valid = x.v;
      in_sof   = x.sof;
      in_data  = x.d;
      @(posedge clk);
      #1;
      tag = $sformatf("v%0d", idx);
      chk({tag, ".ch_strobe"},   32'(ch_strobe),   32'(x.strb));
      chk({tag, ".frame_valid"}, 32'(frame_valid), 32'(x.fv));
      chk({tag, ".err_frame"},   32'(err_frame),   32'(x.err));
      chk({tag, ".locked"},      32'(locked),      32'(x.lk));
      chk({tag, ".ch_data"},     ch_data,          x.ch);
      // scoreboard: each frame_valid must match the next expected frame
      if (sb_on && frame_valid) begin
         if (exp_q.size() == 0) begin
            chk({tag, ".unexpected_frame"}, 32'(1), 32'(0));
         end else begin
            chk({tag, ".sb_frame"}, ch_data, exp_q.pop_front());
         end
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;

      // reset
      tbl[0]  = mk(1,0,0,8'h00,4'b0000,0,0,0,32'h00000000);
      tbl[1]  = mk(1,1,1,8'h5A,4'b0000,0,0,0,32'h00000000);
      // 1: HUNT drops samples without sof
      tbl[2]  = mk(0,1,0,8'hAA,4'b0000,0,0,0,32'h00000000);
      tbl[3]  = mk(0,1,0,8'hBB,4'b0000,0,0,0,32'h00000000);
      tbl[4]  = mk(0,0,0,8'h00,4'b0000,0,0,0,32'h00000000);
      // 2: back-to-back frame
      tbl[5]  = mk(0,1,1,8'h11,4'b0001,0,0,1,32'h00000011);
      tbl[6]  = mk(0,1,0,8'h22,4'b0010,0,0,1,32'h00002211);
      tbl[7]  = mk(0,1,0,8'h33,4'b0100,0,0,1,32'h00332211);
      tbl[8]  = mk(0,1,0,8'h44,4'b1000,1,0,1,32'h44332211);
      tbl[9]  = mk(0,0,0,8'h00,4'b0000,0,0,1,32'h44332211);
      // 3: same frame with two idle cycles between samples
      tbl[10] = mk(0,1,1,8'h11,4'b0001,0,0,1,32'h44332211);
      tbl[11] = mk(0,0,0,8'h00,4'b0000,0,0,1,32'h44332211);
      tbl[12] = mk(0,0,0,8'h00,4'b0000,0,0,1,32'h44332211);
      tbl[13] = mk(0,1,0,8'h22,4'b0010,0,0,1,32'h44332211);
      tbl[14] = mk(0,0,0,8'h00,4'b0000,0,0,1,32'h44332211);
      tbl[15] = mk(0,0,0,8'h00,4'b0000,0,0,1,32'h44332211);
      tbl[16] = mk(0,1,0,8'h33,4'b0100,0,0,1,32'h44332211);
      tbl[17] = mk(0,0,0,8'h00,4'b0000,0,0,1,32'h44332211);
      tbl[18] = mk(0,0,0,8'h00,4'b0000,0,0,1,32'h44332211);
      tbl[19] = mk(0,1,0,8'h44,4'b1000,1,0,1,32'h44332211);
      tbl[20] = mk(0,0,0,8'h00,4'b0000,0,0,1,32'h44332211);
      tbl[21] = mk(0,0,0,8'h00,4'b0000,0,0,1,32'h44332211);
      // 4: sof at slot 2
      tbl[22] = mk(0,1,1,8'h11,4'b0001,0,0,1,32'h44332211);
      tbl[23] = mk(0,1,0,8'h22,4'b0010,0,0,1,32'h44332211);
      tbl[24] = mk(0,1,1,8'h55,4'b0001,0,1,1,32'h44332255);
      tbl[25] = mk(0,1,0,8'h66,4'b0010,0,0,1,32'h44336655);
      tbl[26] = mk(0,1,0,8'h77,4'b0100,0,0,1,32'h44776655);
      tbl[27] = mk(0,1,0,8'h88,4'b1000,1,0,1,32'h88776655);
      tbl[28] = mk(0,0,0,8'h00,4'b0000,0,0,1,32'h88776655);
      // 5: two frames without sof at slot 0
      tbl[29] = mk(0,1,0,8'hA1,4'b0001,0,0,1,32'h887766A1);
      tbl[30] = mk(0,1,0,8'hA2,4'b0010,0,0,1,32'h8877A2A1);
      tbl[31] = mk(0,1,0,8'hA3,4'b0100,0,0,1,32'h88A3A2A1);
      tbl[32] = mk(0,1,0,8'hA4,4'b1000,1,0,1,32'hA4A3A2A1);
      tbl[33] = mk(0,1,0,8'hB1,4'b0000,0,0,0,32'hA4A3A2A1);
      tbl[34] = mk(0,1,0,8'hB2,4'b0000,0,0,0,32'hA4A3A2A1);
      tbl[35] = mk(0,1,1,8'hB3,4'b0001,0,0,1,32'hA4A3A2B3);

      for (int i = 0; i < NVEC; i++) begin
         apply(i, tbl[i]);
      end

      // 6: reset after slot 1 of a frame, then a clean frame
      sb_on = 1'b1;
      exp_q.push_back(32'hD4D3D2D1);
      apply(100, mk(0,1,0,8'hC2,4'b0010,0,0,1,32'hA4A3C2B3));
      apply(101, mk(1,1,1,8'hFF,4'b0000,0,0,0,32'h00000000));
      apply(102, mk(0,1,0,8'hD0,4'b0000,0,0,0,32'h00000000));
      apply(103, mk(0,1,1,8'hD1,4'b0001,0,0,1,32'h000000D1));
      apply(104, mk(0,1,0,8'hD2,4'b0010,0,0,1,32'h0000D2D1));
      apply(105, mk(0,1,0,8'hD3,4'b0100,0,0,1,32'h00D3D2D1));
      apply(106, mk(0,1,0,8'hD4,4'b1000,1,0,1,32'hD4D3D2D1));
      apply(107, mk(0,0,0,8'h00,4'b0000,0,0,1,32'hD4D3D2D1));
      chk("sb_drained", 32'(exp_q.size()), 32'(0));

      // report
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
